// File: rtl/trng_vn_packer.sv
// trng_vn_packer: von Neumann de-biasing of a raw TRNG bit stream, packing of
// corrected bits into bytes, a small output FIFO with valid/ready handshake,
// and a repetition-count health test that blocks the source when it sticks.
module trng_vn_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            raw_bit,
  input  logic                            raw_valid,
  input  logic                            en,
  input  logic                            clr_status,
  output logic [7:0]                      byte_out,
  output logic                            byte_valid,
  input  logic                            byte_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            health_fail,
  output logic                            overflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    VN_EMPTY = 1'b0,
    VN_HALF  = 1'b1
  } vn_state_e;

  vn_state_e   vn_state, vn_state_next;
  logic        first_bit, first_bit_next;
  logic        emit_valid;
  logic        emit_bit;

  logic [6:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        byte_done;
  logic [7:0]  byte_data;

  logic [7:0]  run;
  logic [7:0]  run_next;
  logic        prev_bit;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;

  // A raw bit is consumed only when conditioning is live and no clear is pending.
  logic accept;
  logic flush;
  assign accept = raw_valid & en & ~health_fail & ~clr_status;
  assign flush  = clr_status | health_fail | ~en;

  // Corrector next state and emitted bit: a 01 pair yields 0, 10 yields 1,
  // which is exactly the first bit of any unequal pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    vn_state_next  = vn_state;
    first_bit_next = first_bit;
    emit_valid     = 1'b0;
    emit_bit       = first_bit;
    if (flush) begin
      vn_state_next = VN_EMPTY;
    end else if (accept) begin
      case (vn_state)
        VN_EMPTY: begin
          first_bit_next = raw_bit;
          vn_state_next  = VN_HALF;
        end
        VN_HALF: begin
          vn_state_next = VN_EMPTY;
          emit_valid    = first_bit ^ raw_bit;
        end
        default: vn_state_next = VN_EMPTY;
      endcase
    end
  end

  // Corrector state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) begin
      vn_state  <= VN_EMPTY;
      first_bit <= 1'b0;
    end else begin
      vn_state  <= vn_state_next;
      first_bit <= first_bit_next;
    end
  end

  // The completing bit goes straight into the byte, so only seven bits are held.
  assign byte_done = emit_valid & (bit_cnt == 3'd7);
  assign byte_data = {shreg, emit_bit};

  // Packer: shift emitted bits in at the LSB; any flush discards a partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (flush) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (emit_valid) begin
      shreg   <= {shreg[5:0], emit_bit};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Run length seen by the repetition test, restarting at 1 on a new value.
  always_comb begin
    run_next = run;
    if (run == 8'd0 || raw_bit != prev_bit) begin
      run_next = 8'd1;
    end else if (run < 8'(REP_LIMIT)) begin
      run_next = run + 8'd1;
    end
  end

  // Repetition test and sticky status flags; clr_status wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= '0;
      prev_bit    <= 1'b0;
      health_fail <= 1'b0;
      overflow    <= 1'b0;
    end else if (clr_status) begin
      run         <= '0;
      prev_bit    <= 1'b0;
      health_fail <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (accept) begin
        run      <= run_next;
        prev_bit <= raw_bit;
        if (run_next == 8'(REP_LIMIT)) health_fail <= 1'b1;
      end
      if (byte_done && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign byte_valid = (fifo_count != '0);
  assign pop        = byte_valid & byte_ready;
  assign push_ok    = byte_done & (~fifo_full | pop);
  assign byte_out   = mem[rd_ptr];

  // Output FIFO; a full FIFO still takes a byte when the head leaves that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage is reset because byte_out shows the head entry directly
    // and must read 0x00 out of reset; at this depth the cost is negligible.
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= byte_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
